// File: rtl/julia_pkg.sv
// Shared constants and state encoding for the Julia-set escape-time engine.
package julia_pkg;

  localparam int WIDTH   = 16;
  localparam int FRAC    = 12;
  localparam int COUNT_W = 8;

  localparam logic [WIDTH-1:0]   Q_ONE     = WIDTH'(1 << FRAC);
  localparam logic [2*WIDTH:0]   ESCAPE_R2 = (2*WIDTH+1)'(4) << (2*FRAC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/julia_step.sv
// One combinational Julia iteration: z' = z^2 + c, plus the full-precision |z|^2.
module julia_step #(
  parameter int WIDTH = julia_pkg::WIDTH,
  parameter int FRAC  = julia_pkg::FRAC
) (
  input  logic signed [WIDTH-1:0] zr,
  input  logic signed [WIDTH-1:0] zi,
  input  logic signed [WIDTH-1:0] cr,
  input  logic signed [WIDTH-1:0] ci,
  output logic signed [WIDTH-1:0] zr_next,
  output logic signed [WIDTH-1:0] zi_next,
  output logic        [2*WIDTH:0] mag
);

  localparam int P = 2*WIDTH + 2;

  logic signed [P-1:0] zr_x, zi_x, cr_x, ci_x;
  logic signed [P-1:0] rr, ii, ri;

  // Sign-extend first so every product and shift is evaluated at full width.
  assign zr_x = {{(P-WIDTH){zr[WIDTH-1]}}, zr};
  assign zi_x = {{(P-WIDTH){zi[WIDTH-1]}}, zi};
  assign cr_x = {{(P-WIDTH){cr[WIDTH-1]}}, cr};
  assign ci_x = {{(P-WIDTH){ci[WIDTH-1]}}, ci};

  assign rr = zr_x * zr_x;
  assign ii = zi_x * zi_x;
  assign ri = zr_x * zi_x;

  assign mag     = (2*WIDTH+1)'(rr + ii);
  assign zr_next = WIDTH'(((rr - ii) >>> FRAC) + cr_x);
  assign zi_next = WIDTH'(((ri <<< 1) >>> FRAC) + ci_x);

endmodule

// File: rtl/julia_iter.sv
// Escape-time engine shell: valid/ready handshake around one julia_step per clock.
module julia_iter #(
  parameter int WIDTH    = julia_pkg::WIDTH,
  parameter int FRAC     = julia_pkg::FRAC,
  parameter int MAX_ITER = 31,
  parameter int TAG_W    = 19
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_zr,
  input  logic signed [WIDTH-1:0] in_zi,
  input  logic signed [WIDTH-1:0] in_cr,
  input  logic signed [WIDTH-1:0] in_ci,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              out_count,
  output logic [TAG_W-1:0]        out_tag
);

  import julia_pkg::*;

  localparam logic [2*WIDTH:0]   ESC_R2 = (2*WIDTH+1)'(4) << (2*FRAC);
  localparam logic [COUNT_W-1:0] N_MAX  = COUNT_W'(MAX_ITER);

  state_t state_reg, state_next;

  logic signed [WIDTH-1:0] zr_reg, zi_reg, cr_reg, ci_reg;
  logic signed [WIDTH-1:0] zr_step, zi_step;
  logic [2*WIDTH:0]        mag;
  logic [COUNT_W-1:0]      n_reg, count_reg;
  logic [TAG_W-1:0]        tag_reg, out_tag_reg;
  logic                    escape, capped;

  julia_step #(.WIDTH(WIDTH), .FRAC(FRAC)) u_step (
    .zr      (zr_reg),
    .zi      (zi_reg),
    .cr      (cr_reg),
    .ci      (ci_reg),
    .zr_next (zr_step),
    .zi_next (zi_step),
    .mag     (mag)
  );

  // Escape is judged on the current z before any update; exactly 4.0 stays in.
  assign escape = (mag > ESC_R2);
  assign capped = (n_reg == N_MAX);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (in_valid)           state_next = ITER;
      ITER: if (escape || capped)   state_next = DONE;
      DONE: if (out_ready)          state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      zr_reg      <= '0;
      zi_reg      <= '0;
      cr_reg      <= '0;
      ci_reg      <= '0;
      n_reg       <= '0;
      tag_reg     <= '0;
      count_reg   <= '0;
      out_tag_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            zr_reg  <= in_zr;
            zi_reg  <= in_zi;
            cr_reg  <= in_cr;
            ci_reg  <= in_ci;
            tag_reg <= in_tag;
            n_reg   <= '0;
          end
        end
        ITER: begin
          if (escape || capped) begin
            count_reg   <= n_reg;
            out_tag_reg <= tag_reg;
          end else begin
            zr_reg <= zr_step;
            zi_reg <= zi_step;
            n_reg  <= n_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign out_count = count_reg;
  assign out_tag   = out_tag_reg;

endmodule

// File: tb/tb_julia_iter.sv
// Directed-vector bench for julia_iter: escape counts, latency, backpressure, mid-pixel reset.
module tb_julia_iter;

  import julia_pkg::*;

  localparam int TAG_W = 19;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_zr, in_zi, in_cr, in_ci;
  logic [TAG_W-1:0]        in_tag;
  logic                    out_valid;
  logic                    out_ready;
  logic [7:0]              out_count;
  logic [TAG_W-1:0]        out_tag;

  int n_cmp = 0;
  int n_err = 0;

  julia_iter #(.WIDTH(WIDTH), .FRAC(FRAC), .MAX_ITER(31), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_zr     (in_zr),
    .in_zi     (in_zi),
    .in_cr     (in_cr),
    .in_ci     (in_ci),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a pixel, measure latency, hold backpressure for `hold` cycles, then drain.
  task automatic run_pixel(input logic [15:0] zr, input logic [15:0] zi,
                           input logic [15:0] cr, input logic [15:0] ci,
                           input logic [TAG_W-1:0] tag, input int exp_count, input int hold);
    int lat;
    check_eq("in_ready_before", in_ready, 1);
    in_zr = zr; in_zi = zi; in_cr = cr; in_ci = ci; in_tag = tag;
    in_valid = 1'b1;
    tick();
    // Garbage on the input while busy must be ignored.
    in_zr = 16'h7FFF; in_zi = 16'h7FFF; in_tag = ~tag;
    lat = 1;
    while (!out_valid && lat < 300) begin
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check_eq("timeout", out_valid, 1);
    check_eq("latency", lat, exp_count + 2);
    check_eq("count", out_count, exp_count);
    check_eq("tag", out_tag, tag);
    check_eq("in_ready_done", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_count", out_count, exp_count);
      check_eq("hold_tag", out_tag, tag);
      check_eq("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("drain_valid", out_valid, 0);
    check_eq("drain_in_ready", in_ready, 1);
    $display("pixel tag=%0d z0=(%h,%h) c=(%h,%h) count=%0d latency=%0d", tag, zr, zi, cr, ci, out_count, lat);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_zr = '0; in_zi = '0; in_cr = '0; in_ci = '0; in_tag = '0;
    repeat (3) tick();
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_count", out_count, 0);
    check_eq("rst_out_tag", out_tag, 0);
    check_eq("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_in_ready", in_ready, 1);

    run_pixel(16'h0000, 16'h0000, 16'h0000, 16'h0000, 19'd5,  31, 0);
    run_pixel(16'h3000, 16'h0000, 16'h0000, 16'h0000, 19'd6,  0,  0);
    run_pixel(16'h0000, 16'h0000, Q_ONE,    16'h0000, 19'd7,  3,  0);
    run_pixel(16'h0000, 16'h0000, 16'hE000, 16'h0000, 19'd8,  31, 0);
    // |z0|^2 exactly 4.0 stays, next step reaches 16 and escapes.
    run_pixel(16'h2000, 16'h0000, 16'h0000, 16'h0000, 19'd9,  1,  0);
    // One LSB above 4.0 escapes immediately.
    run_pixel(16'h2000, 16'h0001, 16'h0000, 16'h0000, 19'd10, 0,  0);
    // 1+i -> 2i -> -4: exercises the cross term and sign handling.
    run_pixel(Q_ONE,    Q_ONE,    16'h0000, 16'h0000, 19'h7FFFF, 2, 0);
    run_pixel(16'h0000, Q_ONE,    16'h0000, 16'h0000, 19'd12, 31, 0);
    // Backpressure in DONE for 5 cycles.
    run_pixel(16'h0000, 16'h0000, Q_ONE,    16'h0000, 19'd13, 3,  5);

    // Reset mid-ITER abandons the pixel.
    in_zr = '0; in_zi = '0; in_cr = '0; in_ci = '0; in_tag = 19'd14;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_in_ready", in_ready, 1);
    check_eq("midrst_out_count", out_count, 0);
    check_eq("midrst_out_tag", out_tag, 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check_eq("midrst_no_output", seen, 0);
    $display("pixel tag=14 abandoned by reset, spurious outputs=%0d", seen);
    run_pixel(16'h3000, 16'h0000, 16'h0000, 16'h0000, 19'd15, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
